// File: rtl/xbox_pkg.sv
// Shared sizing constants and FSM state type for the PUM-row to XBOX-beat adapter.
package xbox_pkg;

  localparam int ROW_W  = 1024;
  localparam int BEAT_W = 128;
  localparam int ADDR_W = 14;
  localparam int NBEAT  = ROW_W / BEAT_W;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RD_WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/xbox_row_adapter.sv
// Splits single-cycle PUM row reads/writes into NBEAT consecutive XBOX macro beats
// and reassembles read beats into a full row, published only when complete.
module xbox_row_adapter #(
  parameter int ROW_W  = xbox_pkg::ROW_W,
  parameter int BEAT_W = xbox_pkg::BEAT_W,
  parameter int ADDR_W = xbox_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pum_XBOX_rd,
  input  logic                pum_XBOX_wr,
  input  logic [ADDR_W-1:0]   pum_XBOX_addr,
  input  logic [ROW_W-1:0]    pum_XBOX_wdata,
  output logic [ROW_W-1:0]    pum_XBOX_rdata,
  output logic                pum_XBOX_busy,
  output logic                pum_XBOX_done,
  output logic                pum_XBOX_ovf,
  output logic                xbox_en,
  output logic                xbox_we,
  output logic [ADDR_W+2:0]   xbox_addr,
  output logic [BEAT_W-1:0]   xbox_wdata,
  input  logic [BEAT_W-1:0]   xbox_rdata
);

  import xbox_pkg::*;

  localparam logic [2:0] LAST_BEAT = 3'(ROW_W / BEAT_W - 1);
  localparam int         TOP_OFF   = ROW_W - BEAT_W;

  state_e              r_state;
  logic [2:0]          r_beat;
  logic [ADDR_W-1:0]   r_row_addr;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    r_cap;
  logic [ROW_W-1:0]    r_rdata;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic                r_en;
  logic                r_we;
  logic [ADDR_W+2:0]   r_xaddr;
  logic [BEAT_W-1:0]   r_xwdata;

  logic [2:0]          w_next_beat;
  logic [2:0]          w_prev_beat;
  logic                w_req;

  assign w_next_beat = r_beat + 3'd1;
  assign w_prev_beat = r_beat - 3'd1;
  assign w_req       = pum_XBOX_rd | pum_XBOX_wr;

  // NOTE: every state register updates with <= so all of them see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_row_addr <= '0;
      r_row      <= '0;
      r_cap      <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_xaddr    <= '0;
      r_xwdata   <= '0;
    end else begin
      // NOTE: pulses default low here so each branch only states when they fire.
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_row_addr <= pum_XBOX_addr;
            r_beat     <= 3'd0;
            r_busy     <= 1'b1;
            r_en       <= 1'b1;
            r_xaddr    <= {pum_XBOX_addr, 3'd0};
            if (pum_XBOX_wr) begin
              // A simultaneous read loses to the write and is flagged.
              r_row    <= pum_XBOX_wdata;
              r_we     <= 1'b1;
              r_xwdata <= pum_XBOX_wdata[0 +: BEAT_W];
              r_ovf    <= pum_XBOX_rd;
              r_state  <= WRITE;
            end else begin
              r_we    <= 1'b0;
              r_state <= READ;
            end
          end
        end

        WRITE: begin
          r_ovf <= w_req;
          if (r_beat == LAST_BEAT) begin
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_beat   <= w_next_beat;
            r_xaddr  <= {r_row_addr, w_next_beat};
            r_xwdata <= r_row[int'(w_next_beat) * BEAT_W +: BEAT_W];
          end
        end

        READ: begin
          r_ovf <= w_req;
          // Read data lags its strobe by one cycle, so this edge holds the previous beat.
          if (r_beat != 3'd0) begin
            r_cap[int'(w_prev_beat) * BEAT_W +: BEAT_W] <= xbox_rdata;
          end
          if (r_beat == LAST_BEAT) begin
            r_en    <= 1'b0;
            r_state <= RD_WAIT;
          end else begin
            r_beat  <= w_next_beat;
            r_xaddr <= {r_row_addr, w_next_beat};
          end
        end

        RD_WAIT: begin
          r_ovf                     <= w_req;
          r_cap[TOP_OFF +: BEAT_W]  <= xbox_rdata;
          r_rdata                   <= {xbox_rdata, r_cap[TOP_OFF-1:0]};
          r_done                    <= 1'b1;
          r_state                   <= DONE;
        end

        DONE: begin
          r_ovf   <= w_req;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign pum_XBOX_rdata = r_rdata;
  assign pum_XBOX_busy  = r_busy;
  assign pum_XBOX_done  = r_done;
  assign pum_XBOX_ovf   = r_ovf;
  assign xbox_en        = r_en;
  assign xbox_we        = r_we;
  assign xbox_addr      = r_xaddr;
  assign xbox_wdata     = r_xwdata;

endmodule

// File: tb/tb_xbox_row_adapter.sv
// Directed bench for xbox_row_adapter: write/read latency, collisions, mid-op reset, back-to-back reads.
module tb_xbox_row_adapter;

  localparam int ROW_W  = 1024;
  localparam int BEAT_W = 128;
  localparam int ADDR_W = 14;

  logic                clk;
  logic                rst_n;
  logic                pum_XBOX_rd;
  logic                pum_XBOX_wr;
  logic [ADDR_W-1:0]   pum_XBOX_addr;
  logic [ROW_W-1:0]    pum_XBOX_wdata;
  logic [ROW_W-1:0]    pum_XBOX_rdata;
  logic                pum_XBOX_busy;
  logic                pum_XBOX_done;
  logic                pum_XBOX_ovf;
  logic                xbox_en;
  logic                xbox_we;
  logic [ADDR_W+2:0]   xbox_addr;
  logic [BEAT_W-1:0]   xbox_wdata;
  logic [BEAT_W-1:0]   xbox_rdata;

  int n_pass   = 0;
  int n_checks = 0;

  xbox_row_adapter #(.ROW_W(ROW_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pum_XBOX_rd    (pum_XBOX_rd),
    .pum_XBOX_wr    (pum_XBOX_wr),
    .pum_XBOX_addr  (pum_XBOX_addr),
    .pum_XBOX_wdata (pum_XBOX_wdata),
    .pum_XBOX_rdata (pum_XBOX_rdata),
    .pum_XBOX_busy  (pum_XBOX_busy),
    .pum_XBOX_done  (pum_XBOX_done),
    .pum_XBOX_ovf   (pum_XBOX_ovf),
    .xbox_en        (xbox_en),
    .xbox_we        (xbox_we),
    .xbox_addr      (xbox_addr),
    .xbox_wdata     (xbox_wdata),
    .xbox_rdata     (xbox_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro read beat k of a row; row 0x0011 yields {4{32'hF0F0_000k}}.
  function automatic logic [BEAT_W-1:0] rbeat(input logic [ADDR_W-1:0] row, input logic [2:0] k);
    logic [31:0] w;
    w = 32'hF0F0_0000 + {29'd0, k} + {10'd0, row ^ 14'h0011, 8'd0};
    return {4{w}};
  endfunction

  function automatic logic [ROW_W-1:0] rrow(input logic [ADDR_W-1:0] row);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*BEAT_W +: BEAT_W] = rbeat(row, 3'(k));
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] wrow(input logic [31:0] base);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*BEAT_W +: BEAT_W] = {4{base + 32'(k)}};
    return r;
  endfunction

  // Macro model: data for a read strobe appears in the following cycle, junk otherwise.
  always @(posedge clk) begin
    if (xbox_en === 1'b1 && xbox_we === 1'b0)
      xbox_rdata <= rbeat(xbox_addr[ADDR_W+2:3], xbox_addr[2:0]);
    else
      xbox_rdata <= {4{32'hDEAD_BEEF}};
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_row(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s[%0d]", tag, k), got[k*BEAT_W +: BEAT_W], exp[k*BEAT_W +: BEAT_W]);
  endtask

  // Drives a request for one cycle; returns at the negedge of cycle 1 after the sample edge.
  task automatic start_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [ROW_W-1:0] d);
    @(negedge clk);
    pum_XBOX_rd    = rd;
    pum_XBOX_wr    = wr;
    pum_XBOX_addr  = a;
    pum_XBOX_wdata = d;
    @(negedge clk);
    pum_XBOX_rd = 1'b0;
    pum_XBOX_wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [ROW_W-1:0] wr_row;
    int n_w, n_r, n_en, n_done;

    rst_n          = 1'b0;
    pum_XBOX_rd    = 1'b0;
    pum_XBOX_wr    = 1'b0;
    pum_XBOX_addr  = '0;
    pum_XBOX_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_busy",  pum_XBOX_busy, 0);
    check("rst_done",  pum_XBOX_done, 0);
    check("rst_ovf",   pum_XBOX_ovf, 0);
    check("rst_en",    xbox_en, 0);
    check("rst_we",    xbox_we, 0);
    check("rst_addr",  xbox_addr, 0);
    check("rst_wdata", xbox_wdata, 0);
    check_row("rst_rdata", pum_XBOX_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", pum_XBOX_busy, 0);

    // Full-row write to 0x3A5.
    wr_row = wrow(32'h1000_0000);
    start_req(1'b0, 1'b1, 14'h3A5, wr_row);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 8) begin
        check($sformatf("w_en_c%0d", c), xbox_en, 1);
        check($sformatf("w_we_c%0d", c), xbox_we, 1);
        check($sformatf("w_addr_c%0d", c), xbox_addr, {14'h3A5, 3'(c-1)});
        check($sformatf("w_wdata_c%0d", c), xbox_wdata, {4{32'h1000_0000 + 32'(c-1)}});
        check($sformatf("w_done_c%0d", c), pum_XBOX_done, 0);
      end
      if (c == 1) check("w_ovf_c1", pum_XBOX_ovf, 0);
      if (c <= 9) check($sformatf("w_busy_c%0d", c), pum_XBOX_busy, 1);
      if (c == 9) begin
        check("w_done_c9", pum_XBOX_done, 1);
        check("w_en_c9", xbox_en, 0);
      end
      if (c == 10) begin
        check("w_done_c10", pum_XBOX_done, 0);
        check("w_busy_c10", pum_XBOX_busy, 0);
      end
    end

    // Full-row read of 0x0011.
    start_req(1'b1, 1'b0, 14'h0011, '0);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      check($sformatf("r_busy_c%0d", c), pum_XBOX_busy, 1);
      if (c <= 8) begin
        check($sformatf("r_en_c%0d", c), xbox_en, 1);
        check($sformatf("r_we_c%0d", c), xbox_we, 0);
        check($sformatf("r_addr_c%0d", c), xbox_addr, {14'h0011, 3'(c-1)});
      end
      if (c == 9) begin
        check("r_en_c9", xbox_en, 0);
        check("r_done_c9", pum_XBOX_done, 0);
        check("r_partial_lo", pum_XBOX_rdata[127:0], 0);
        check("r_partial_hi", pum_XBOX_rdata[1023:896], 0);
      end
      if (c == 10) begin
        check("r_done_c10", pum_XBOX_done, 1);
        check_row("r_row11", pum_XBOX_rdata, rrow(14'h0011));
      end
    end

    // Back-to-back read of 0x0022 in the cycle after done.
    start_req(1'b1, 1'b0, 14'h0022, '0);
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        check("b2b_busy_c1", pum_XBOX_busy, 1);
        check("b2b_ovf_c1", pum_XBOX_ovf, 0);
        check("b2b_addr_c1", xbox_addr, {14'h0022, 3'd0});
      end
      if (c == 9) begin
        check("b2b_hold_lo", pum_XBOX_rdata[127:0], rrow(14'h0011) >> 0);
        check("b2b_hold_hi", pum_XBOX_rdata[1023:896], rbeat(14'h0011, 3'd7));
        check("b2b_done_c9", pum_XBOX_done, 0);
      end
      if (c == 10) begin
        check("b2b_done_c10", pum_XBOX_done, 1);
        check_row("b2b_row22", pum_XBOX_rdata, rrow(14'h0022));
      end
      if (c == 11) check("b2b_done_c11", pum_XBOX_done, 0);
    end

    // Simultaneous rd and wr at 0x5: write wins, read dropped.
    n_w = 0;
    n_r = 0;
    start_req(1'b1, 1'b1, 14'h0005, wrow(32'hA500_0000));
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (xbox_en === 1'b1 && xbox_we === 1'b1) n_w++;
      if (xbox_en === 1'b1 && xbox_we === 1'b0) n_r++;
      if (c == 1) check("rw_ovf_c1", pum_XBOX_ovf, 1);
      if (c == 2) check("rw_ovf_c2", pum_XBOX_ovf, 0);
      if (c == 3) begin
        check("rw_addr_c3", xbox_addr, {14'h0005, 3'd2});
        check("rw_wdata_c3", xbox_wdata, {4{32'hA500_0002}});
      end
      if (c == 9) check("rw_done_c9", pum_XBOX_done, 1);
    end
    check("rw_wbeats", n_w, 8);
    check("rw_rbeats", n_r, 0);
    check("rw_rdata_held", pum_XBOX_rdata[1023:896], rbeat(14'h0022, 3'd7));

    // Write request in cycle 4 of a read of 0x30 is ignored.
    n_w = 0;
    start_req(1'b1, 1'b0, 14'h0030, '0);
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) @(negedge clk);
      if (xbox_we === 1'b1) n_w++;
      if (c == 4) check("ov_ovf_c4", pum_XBOX_ovf, 0);
      if (c == 5) check("ov_ovf_c5", pum_XBOX_ovf, 1);
      if (c == 6) check("ov_ovf_c6", pum_XBOX_ovf, 0);
      if (c == 8) check("ov_addr_c8", xbox_addr, {14'h0030, 3'd7});
      if (c == 10) begin
        check("ov_done_c10", pum_XBOX_done, 1);
        check_row("ov_row30", pum_XBOX_rdata, rrow(14'h0030));
      end
      if (c == 11) begin
        check("ov_done_c11", pum_XBOX_done, 0);
        check("ov_busy_c11", pum_XBOX_busy, 0);
      end
      if (c == 4) begin
        pum_XBOX_wr    = 1'b1;
        pum_XBOX_addr  = 14'h07FF;
        pum_XBOX_wdata = wrow(32'h7700_0000);
      end
      if (c == 5) pum_XBOX_wr = 1'b0;
    end
    check("ov_no_wbeats", n_w, 0);

    // Reset asserted in cycle 3 of a write to 0x100 aborts it.
    start_req(1'b0, 1'b1, 14'h0100, wrow(32'h5500_0000));
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) begin
        check("ra_en_c3", xbox_en, 1);
        check("ra_addr_c3", xbox_addr, {14'h0100, 3'd2});
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("ra_busy", pum_XBOX_busy, 0);
    check("ra_en", xbox_en, 0);
    check("ra_rdata", pum_XBOX_rdata[127:0], 0);
    n_en   = 0;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (xbox_en !== 1'b0) n_en++;
      if (pum_XBOX_done !== 1'b0) n_done++;
    end
    check("ra_no_en", n_en, 0);
    check("ra_no_done", n_done, 0);

    start_req(1'b1, 1'b0, 14'h02A5, '0);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) check("ra_rd_addr_c1", xbox_addr, {14'h02A5, 3'd0});
      if (c == 9) check("ra_rd_done_c9", pum_XBOX_done, 0);
      if (c == 10) begin
        check("ra_rd_done_c10", pum_XBOX_done, 1);
        check_row("ra_row2a5", pum_XBOX_rdata, rrow(14'h02A5));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
